muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit for the multicycle core.
- Sits downstream of the operand latch and consumes the latched rs1/rs2 pair.
- Runs a fixed-latency shift-add multiply or restoring divide, then returns one XLEN result to the write-back path.
- The control FSM stalls on busy_o and proceeds on done_o.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: XLEN, the funct3-coded multiply/divide opcodes and the
// muldiv control states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide on
// operand magnitudes, then one sign-fix cycle. Fixed latency for every op.
module muldiv_unit #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import riscv_pkg::*;

  localparam int unsigned ITER = XLEN;
  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Launch-time decode of the incoming operands.
  muldiv_op_e      op_in;
  logic            is_mul_in, a_neg_in, b_neg_in, neg_in, ovf_in;
  logic [XLEN-1:0] a_abs, b_abs;

  assign op_in     = muldiv_op_e'(op_i);
  assign is_mul_in = ~op_i[2];
  assign a_neg_in  = rs1_i[XLEN-1] & (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
  assign b_neg_in  = rs2_i[XLEN-1] & (op_in inside {OpMulh, OpDiv, OpRem});
  assign a_abs     = a_neg_in ? (~rs1_i + 1'b1) : rs1_i;
  assign b_abs     = b_neg_in ? (~rs2_i + 1'b1) : rs2_i;
  // Remainder follows the dividend sign; everything else is the XOR of both.
  assign neg_in    = (op_in == OpRem) ? a_neg_in : (a_neg_in ^ b_neg_in);
  assign ovf_in    = (op_in inside {OpDiv, OpRem}) && (rs1_i == MinVal) && (rs2_i == '1);

  // acc_q holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] fix_sel, fix_val;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    unique case (op_q)
      OpDiv, OpDivu: fix_sel = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
      OpRem, OpRemu: fix_sel = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
      default:       fix_sel = acc_q;
    endcase
  end

  assign fix_val = cond_neg(fix_sel, neg_q);

  always_comb begin
    unique case (op_q)
      OpMul:                      fix_res = fix_val[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  fix_res = fix_val[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              fix_res = dz_q ? '1 : (ovf_q ? MinVal : fix_val[XLEN-1:0]);
      OpRem, OpRemu:              fix_res = ovf_q ? '0 : fix_val[XLEN-1:0];
      default:                    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_d    = op_in;
            opnd_d  = is_mul_in ? a_abs : b_abs;
            acc_d   = {{XLEN{1'b0}}, (is_mul_in ? b_abs : a_abs)};
            cnt_d   = '0;
            neg_d   = neg_in;
            dz_d    = (rs2_i == '0);
            ovf_d   = ovf_in;
            state_d = StCalc;
          end
        end
        StCalc: begin
          acc_d = (op_q inside {OpDiv, OpDivu, OpRem, OpRemu}) ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StFix;
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q inside {StCalc, StFix});
  assign done_o   = (state_q == StDone) & ~flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model with a
// launch-to-done timeline, checked every cycle, plus literal expectations.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .rs1_i   (rs1),
    .rs2_i   (rs2),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa32, sb32;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa32 = a;
    sb32 = b;
    sa = sa32;
    sb = sb32;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MUL:    begin p = ua * ub;           return p[31:0];  end
      MULH:   begin p = sa * sb;           return p[63:32]; end
      MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULHU:  begin p = ua * ub;           return p[63:32]; end
      DIV:    begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM:    begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      REMU:   return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Model: m_cnt counts cycles since launch (0 = idle); done appears at LAT.
  int          m_cnt = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_res <= '0;
    end else if (flush) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  <= 1;
        m_pend <= ref_result(op, rs1, rs2);
      end
    end else if (m_cnt == LAT) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= LAT - 1));
    check("done", 32'(done), 32'(m_cnt == LAT && !flush));
    check("result", result, m_res);
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int k, nb;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
    k  = 1;
    nb = busy ? 1 : 0;
    while (!done && k < LAT + 6) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
    end
    check({name, " latency"}, 32'(k), 32'(LAT));
    check({name, " busy cycles"}, 32'(nb), 32'(LAT - 1));
    check({name, " value"}, result, exp);
    @(negedge clk);
  endtask

  initial begin
    int k, ndone;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    rs1   = '0;
    rs2   = '0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2);
    run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu 5/0", REMU, 32'd5, 32'd0, 32'd5);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);

    // Second start mid-operation must be ignored.
    start = 1'b1;
    op    = DIV;
    rs1   = 32'd100;
    rs2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < LAT + 6) begin
      @(negedge clk);
      k++;
      start = (k == 10);
      op    = MUL;
      rs1   = 32'd3;
      rs2   = 32'd3;
    end
    start = 1'b0;
    check("ignored start latency", 32'(k), 32'(LAT));
    check("ignored start value", result, 32'd14);
    @(negedge clk);

    // Flush mid-operation: no done, result held.
    start = 1'b1;
    op    = DIVU;
    rs1   = 32'hFFFF_FFFF;
    rs2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush no done", 32'(ndone), 32'd0);
    check("flush result held", result, 32'd14);
    run_op("remu after flush", REMU, 32'd100, 32'd7, 32'd2);

    // Flush beats start in idle.
    flush = 1'b1;
    start = 1'b1;
    op    = MUL;
    rs1   = 32'd5;
    rs2   = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush+start busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-calculation.
    start = 1'b1;
    op    = MUL;
    rs1   = 32'h1234;
    rs2   = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("mul 3*4", MUL, 32'd3, 32'd4, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
